// File: rtl/a2d_spi_intf.sv
// a2d_spi_intf: mode-3 SPI master running two 16-bit frames per conversion on an ADC128S-style ADC.
// Define A2D_RES_INV_EN to load the bitwise inverse of the received sample into res.
module a2d_spi_intf (
    input  logic        clk,
    input  logic        rst,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    output logic        cnv_cmplt,
    output logic [11:0] res,
    output logic        a2d_SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    typedef enum logic [1:0] {IDLE, XFER1, GAP, XFER2} state_t;

    state_t      state, state_next;
    logic [9:0]  cnt;
    logic [4:0]  div;
    logic        rose;
    logic [15:0] tx;
    logic [11:0] rx;
    logic [2:0]  chnnl_q;
    logic        ss_n;
    logic        accept, frame_start, frame_run, frame_end, gap_run, conv_done;

    assign a2d_SS_n = ss_n;
    assign SCLK     = div[4];
    assign MOSI     = tx[15];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // XFER1 spends its first cycle (cnt==0) as setup so slave select falls one edge after acceptance.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        frame_start = 1'b0;
        frame_run   = 1'b0;
        frame_end   = 1'b0;
        gap_run     = 1'b0;
        conv_done   = 1'b0;
        case (state)
            IDLE: begin
                if (strt_cnv) begin
                    accept     = 1'b1;
                    state_next = XFER1;
                end
            end
            XFER1: begin
                if (cnt == 10'd0) begin
                    frame_start = 1'b1;
                end else if (cnt == 10'd528) begin
                    frame_end  = 1'b1;
                    state_next = GAP;
                end else begin
                    frame_run = 1'b1;
                end
            end
            GAP: begin
                if (cnt == 10'd31) begin
                    frame_start = 1'b1;
                    state_next  = XFER2;
                end else begin
                    gap_run = 1'b1;
                end
            end
            XFER2: begin
                if (cnt == 10'd528) begin
                    frame_end  = 1'b1;
                    conv_done  = 1'b1;
                    state_next = IDLE;
                end else begin
                    frame_run = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The first SCLK fall of a frame does not shift, so each rise samples bits 15..0 in order.
    // Only the last 12 MISO samples are kept; the four leading bits fall off the end.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            div       <= 5'b10000;
            rose      <= 1'b0;
            tx        <= '0;
            rx        <= '0;
            chnnl_q   <= '0;
            ss_n      <= 1'b1;
            cnv_cmplt <= 1'b0;
            res       <= '0;
        end else begin
            if (accept) begin
                chnnl_q <= chnnl;
                cnt     <= '0;
            end
            if (gap_run) cnt <= cnt + 10'd1;
            if (frame_start) begin
                ss_n      <= 1'b0;
                div       <= 5'b10000;
                tx        <= {2'b00, chnnl_q, 11'h000};
                rx        <= '0;
                rose      <= 1'b0;
                cnt       <= 10'd1;
                cnv_cmplt <= 1'b0;
            end
            if (frame_run) begin
                cnt <= cnt + 10'd1;
                div <= div + 5'd1;
                if (div == 5'b01111) begin
                    rx   <= {rx[10:0], MISO};
                    rose <= 1'b1;
                end
                if (div == 5'b11111 && rose) tx <= {tx[14:0], 1'b0};
            end
            if (frame_end) begin
                ss_n <= 1'b1;
                div  <= 5'b10000;
                tx   <= '0;
                cnt  <= '0;
                if (conv_done) begin
                    cnv_cmplt <= 1'b1;
`ifdef A2D_RES_INV_EN
                    res <= ~rx;
`else
                    res <= rx;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_a2d_spi_intf.sv
// tb_a2d_spi_intf: drives a2d_spi_intf against an ADC128S-style slave model and checks
// frame timing, command words and results against values derived from the conversion rules.
module tb_a2d_spi_intf;

    logic        clk = 1'b0;
    logic        rst, strt_cnv, miso;
    logic [2:0]  chnnl;
    logic        cnv_cmplt, a2d_SS_n, SCLK, MOSI;
    logic [11:0] res;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] data;
    } vec_t;
    vec_t vecs[$];

    logic [15:0] adc_word = 16'h0000;
    int          ss_falls[$];
    int          ss_rises[$];
    int          rise_counts[$];
    logic [15:0] mosi_words[$];
    logic        ss_prev = 1'b1;
    logic        sclk_prev = 1'b1;
    logic [15:0] mosi_acc = 16'h0000;
    int          rises_in_frame = 0;

    a2d_spi_intf dut (
        .clk       (clk),
        .rst       (rst),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .a2d_SS_n  (a2d_SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (miso)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] ref_res(input logic [11:0] d);
`ifdef A2D_RES_INV_EN
        return ~d;
`else
        return d;
`endif
    endfunction

    function automatic logic [15:0] ref_cmd(input logic [2:0] ch);
        return 16'(ch) << 11;
    endfunction

    // Slave model: records frame edges by clock count, captures MOSI on SCLK rises and
    // presents word bit (15 - rises so far) on MISO, updating at slave-select fall and SCLK falls.
    always @(negedge clk) begin
        if (ss_prev === 1'b1 && a2d_SS_n === 1'b0) begin
            ss_falls.push_back(cyc);
            rises_in_frame = 0;
            mosi_acc = 16'h0000;
            miso = adc_word[15];
        end else if (ss_prev === 1'b0 && a2d_SS_n === 1'b1) begin
            ss_rises.push_back(cyc);
            mosi_words.push_back(mosi_acc);
            rise_counts.push_back(rises_in_frame);
            miso = 1'b0;
        end
        if (a2d_SS_n === 1'b0) begin
            if (sclk_prev === 1'b0 && SCLK === 1'b1) begin
                mosi_acc = {mosi_acc[14:0], MOSI};
                rises_in_frame++;
            end
            if (sclk_prev === 1'b1 && SCLK === 1'b0 && rises_in_frame < 16)
                miso = adc_word[15 - rises_in_frame];
        end
        ss_prev = a2d_SS_n;
        sclk_prev = SCLK;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full conversion; optionally re-pulses strt_cnv with alt_ch so it is sampled at edge N+pulse_at.
    task automatic apply_stimulus(input logic [2:0] ch, input logic [11:0] data, input int pulse_at,
                                  input logic [2:0] alt_ch, input string tag);
        int n;
        int t_done;
        logic [11:0] exp_res;
        logic [15:0] exp_cmd;
        exp_res = ref_res(data);
        exp_cmd = ref_cmd(ch);
        @(negedge clk);
        ss_falls.delete();
        ss_rises.delete();
        rise_counts.delete();
        mosi_words.delete();
        adc_word = {4'h0, data};
        chnnl = ch;
        strt_cnv = 1'b1;
        n = cyc + 1;
        @(negedge clk);
        strt_cnv = 1'b0;
        chnnl = ~ch;
        @(negedge clk);
        check_output({tag, ".cmplt_clear"}, 32'(cnv_cmplt), 32'd0);
        check_output({tag, ".ss_fall"}, 32'(a2d_SS_n), 32'd0);
        t_done = -1;
        for (int i = 0; i < 1300; i++) begin
            strt_cnv = (pulse_at > 0) && (cyc + 1 == n + pulse_at);
            if (strt_cnv) chnnl = alt_ch;
            @(negedge clk);
            if (cnv_cmplt === 1'b1) begin
                t_done = cyc;
                break;
            end
        end
        strt_cnv = 1'b0;
        #1;
        check_output({tag, ".done_edge"}, 32'(t_done), 32'(n + 1089));
        check_output({tag, ".res"}, 32'(res), 32'(exp_res));
        check_output({tag, ".frames"}, 32'(ss_falls.size() * 10 + ss_rises.size()), 32'd22);
        if (ss_falls.size() == 2 && ss_rises.size() == 2) begin
            check_output({tag, ".first_fall"}, 32'(ss_falls[0]), 32'(n + 1));
            check_output({tag, ".frame1_len"}, 32'(ss_rises[0] - ss_falls[0]), 32'd528);
            check_output({tag, ".gap_len"}, 32'(ss_falls[1] - ss_rises[0]), 32'd32);
            check_output({tag, ".frame2_len"}, 32'(ss_rises[1] - ss_falls[1]), 32'd528);
            check_output({tag, ".mosi1"}, 32'(mosi_words[0]), 32'(exp_cmd));
            check_output({tag, ".mosi2"}, 32'(mosi_words[1]), 32'(exp_cmd));
            check_output({tag, ".sclk_rises"}, 32'(rise_counts[0] + rise_counts[1]), 32'd32);
        end
    endtask

    initial begin
        int bad;
        rst = 1'b1;
        strt_cnv = 1'b0;
        chnnl = 3'd0;
        miso = 1'b0;

        vecs.push_back('{ch: 3'd3, data: 12'hABC});
        for (int c = 0; c < 8; c++) begin
            vecs.push_back('{ch: 3'(c), data: 12'h000});
            vecs.push_back('{ch: 3'(c), data: 12'hFFF});
            vecs.push_back('{ch: 3'(c), data: 12'h5A5});
        end
        for (int r = 0; r < 6; r++)
            vecs.push_back('{ch: 3'($urandom_range(0, 7)), data: 12'($urandom)});

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_output("reset.ss_n", 32'(a2d_SS_n), 32'd1);
        check_output("reset.sclk", 32'(SCLK), 32'd1);
        check_output("reset.mosi", 32'(MOSI), 32'd0);
        check_output("reset.cmplt", 32'(cnv_cmplt), 32'd0);
        check_output("reset.res", 32'(res), 32'd0);
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (a2d_SS_n !== 1'b1 || SCLK !== 1'b1 || MOSI !== 1'b0 || cnv_cmplt !== 1'b0 || res !== 12'h000)
                bad++;
        end
        check_output("reset.idle_2000", 32'(bad), 32'd0);

        foreach (vecs[i])
            apply_stimulus(vecs[i].ch, vecs[i].data, 0, 3'd0, $sformatf("vec%0d", i));

        apply_stimulus(3'd5, 12'h3C7, 100, 3'd2, "busy");
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a2d_SS_n !== 1'b1) bad++;
        end
        check_output("busy.no_restart", 32'(bad), 32'd0);

        apply_stimulus(3'd6, 12'h123, 1089, 3'd1, "collide");
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (a2d_SS_n !== 1'b1) bad++;
            if (cnv_cmplt !== 1'b1 || res !== ref_res(12'h123)) bad++;
        end
        check_output("collide.ignored_and_hold", 32'(bad), 32'd0);

        @(negedge clk);
        adc_word = 16'h0777;
        chnnl = 3'd4;
        strt_cnv = 1'b1;
        @(negedge clk);
        strt_cnv = 1'b0;
        repeat (700) @(negedge clk);
        check_output("midrst.in_xfer2", 32'(a2d_SS_n), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("midrst.ss_n", 32'(a2d_SS_n), 32'd1);
        check_output("midrst.sclk", 32'(SCLK), 32'd1);
        check_output("midrst.mosi", 32'(MOSI), 32'd0);
        check_output("midrst.cmplt", 32'(cnv_cmplt), 32'd0);
        check_output("midrst.res", 32'(res), 32'd0);
        bad = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (a2d_SS_n !== 1'b1 || cnv_cmplt !== 1'b0 || res !== 12'h000) bad++;
        end
        check_output("midrst.aborted", 32'(bad), 32'd0);
        apply_stimulus(3'd4, 12'h9E1, 0, 3'd0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
